// File: rtl/memgame_pkg.sv
// Shared types and helpers for the memory-game player-input path.
package memgame_pkg;

    localparam int NUM_BTN = 8;

    typedef logic [2:0] symbol_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } enc_state_t;

    // Index of the highest set bit; callers guarantee a one-hot input.
    function automatic symbol_t onehot_to_sym(input logic [NUM_BTN-1:0] vec);
        symbol_t idx;
        idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (vec[i]) idx = symbol_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_symbol_encoder_btn_sync.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-zero.
module btn_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_symbol_encoder.sv
// Debounces the 8 player buttons and hands one 3-bit symbol per press-release
// to the input-handling logic over valid/ready.
//
// state    | meaning
// IDLE     | waiting for any synchronised button
// DEBOUNCE | snapshot must stay unchanged for DEBOUNCE_CYCLES cycles
// EMIT     | symbol presented, waiting for sym_ready
// RELEASE  | waiting for all buttons up for DEBOUNCE_CYCLES cycles
module button_symbol_encoder
    import memgame_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               sym_ready,
    output logic               sym_valid,
    output symbol_t            sym,
    output logic               multi_err,
    output logic               busy
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] bsync;
    logic [NUM_BTN-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    enc_state_t         state_q, state_d;
    symbol_t            sym_q, sym_d;
    logic               valid_q, valid_d;
    logic               merr_q, merr_d;

    btn_sync #(.WIDTH(NUM_BTN)) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn),
        .q_o   (bsync)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        valid_d = valid_q;
        merr_d  = 1'b0;

        if (!en) begin
            // sym keeps its last value so the consumer never sees it glitch
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bsync != '0) begin
                        snap_d  = bsync;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (bsync == '0) begin
                        state_d = IDLE;
                    end else if (bsync != snap_q) begin
                        snap_d = bsync;
                        cnt_d  = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        if ($onehot(snap_q)) begin
                            sym_d   = onehot_to_sym(snap_q);
                            valid_d = 1'b1;
                            state_d = EMIT;
                        end else begin
                            merr_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (valid_q && sym_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (bsync != '0) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            merr_q  <= merr_d;
        end
    end

    assign sym_valid = valid_q;
    assign sym       = sym_q;
    assign multi_err = merr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_button_symbol_encoder.sv
// Directed bench for button_symbol_encoder with DEBOUNCE_CYCLES=4.
module tb_button_symbol_encoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] btn;
    logic       rdy;
    logic       sym_valid;
    logic [2:0] sym;
    logic       multi_err;
    logic       busy;

    int checks;
    int errors;
    int xfer_cnt;
    int merr_cnt;

    typedef struct {
        logic [7:0] btn;
        logic       en;
        logic       rdy;
        logic       v;
        logic [2:0] s;
        logic       m;
        logic       b;
    } vec_t;

    vec_t vecs[$];

    button_symbol_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .btn       (btn),
        .sym_ready (rdy),
        .sym_valid (sym_valid),
        .sym       (sym),
        .multi_err (multi_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes and error pulses counted mid-cycle, where everything is stable.
    always @(negedge clk) begin
        if (rst_n && sym_valid && rdy) xfer_cnt++;
        if (rst_n && multi_err) merr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [7:0] b, input logic e, input logic r,
                       input logic v, input logic [2:0] s, input logic m, input logic bz);
        vec_t t;
        for (int i = 0; i < n; i++) begin
            t.btn = b; t.en = e; t.rdy = r;
            t.v = v; t.s = s; t.m = m; t.b = bz;
            vecs.push_back(t);
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (sym_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!busy) begin
                found = 1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    initial begin
        int n;
        int x0;
        checks   = 0;
        errors   = 0;
        xfer_cnt = 0;
        merr_cnt = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        btn   = 8'h00;
        rdy   = 1'b0;

        // single press 8'h20 with ready high, then release
        add(2, 8'h20, 1, 1, 0, 3'd0, 0, 0);
        add(4, 8'h20, 1, 1, 0, 3'd0, 0, 1);
        add(1, 8'h20, 1, 1, 1, 3'd5, 0, 1);
        add(1, 8'h20, 1, 1, 0, 3'd5, 0, 1);
        add(5, 8'h00, 1, 1, 0, 3'd5, 0, 1);
        add(1, 8'h00, 1, 1, 0, 3'd5, 0, 0);
        // two buttons together: error pulse, no symbol
        add(2, 8'h09, 1, 1, 0, 3'd5, 0, 0);
        add(4, 8'h09, 1, 1, 0, 3'd5, 0, 1);
        add(1, 8'h09, 1, 1, 0, 3'd5, 1, 1);
        add(2, 8'h09, 1, 1, 0, 3'd5, 0, 1);
        add(5, 8'h00, 1, 1, 0, 3'd5, 0, 1);
        add(1, 8'h00, 1, 1, 0, 3'd5, 0, 0);

        #1;
        check("reset_outputs", int'({sym_valid, sym, multi_err, busy}), 0);
        step();
        step();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            btn = vecs[i].btn;
            en  = vecs[i].en;
            rdy = vecs[i].rdy;
            step();
            check($sformatf("vec%0d {valid,sym,merr,busy}", i),
                  int'({sym_valid, sym, multi_err, busy}),
                  int'({vecs[i].v, vecs[i].s, vecs[i].m, vecs[i].b}));
        end
        check("multi_err_pulses", merr_cnt, 1);
        check("table_xfers", xfer_cnt, 1);

        // back-pressure: symbol held through release until ready
        x0  = xfer_cnt;
        rdy = 1'b0;
        btn = 8'h01;
        wait_valid(20, n);
        check("bp_latency", n, 7);
        check("bp_sym", int'(sym), 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) btn = 8'h00;
            step();
            check("bp_hold_valid", int'(sym_valid), 1);
            check("bp_hold_sym", int'(sym), 0);
        end
        rdy = 1'b1;
        step();
        check("bp_drop", int'(sym_valid), 0);
        step();
        step();
        check("bp_one_xfer", xfer_cnt - x0, 1);
        wait_idle("bp_idle");

        // bounce on button 2, then stable
        x0 = xfer_cnt;
        for (int k = 0; k < 12; k++) begin
            btn = (((k / 2) % 2) == 0) ? 8'h04 : 8'h00;
            step();
            check("bounce_no_valid", int'(sym_valid), 0);
        end
        btn = 8'h04;
        wait_valid(20, n);
        check("bounce_latency", n, 7);
        check("bounce_sym", int'(sym), 2);
        for (int i = 0; i < 10; i++) step();
        check("bounce_one_xfer", xfer_cnt - x0, 1);
        btn = 8'h00;
        wait_idle("bounce_idle");

        // long hold: one symbol, stays in RELEASE
        x0  = xfer_cnt;
        btn = 8'h80;
        wait_valid(20, n);
        check("hold_sym", int'(sym), 7);
        for (int i = 0; i < 50; i++) step();
        check("hold_one_xfer", xfer_cnt - x0, 1);
        check("hold_busy", int'(busy), 1);
        check("hold_no_valid", int'(sym_valid), 0);
        btn = 8'h00;
        wait_idle("hold_idle");
        check("hold_still_one_xfer", xfer_cnt - x0, 1);

        // enable dropped during EMIT, button still held at re-enable
        rdy = 1'b0;
        btn = 8'h02;
        wait_valid(20, n);
        check("en_sym", int'(sym), 1);
        en = 1'b0;
        step();
        check("en_drop_valid", int'(sym_valid), 0);
        check("en_drop_busy", int'(busy), 0);
        check("en_drop_sym_kept", int'(sym), 1);
        x0 = xfer_cnt;
        en = 1'b1;
        wait_valid(20, n);
        check("reenable_latency", n, 5);
        check("reenable_sym", int'(sym), 1);
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("reenable_one_xfer", xfer_cnt - x0, 1);
        check("reenable_busy", int'(busy), 1);
        btn = 8'h00;
        wait_idle("reenable_idle");

        // asynchronous reset in the middle of debounce
        btn = 8'h10;
        step();
        step();
        step();
        check("rst_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", int'({sym_valid, sym, multi_err, busy}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_valid(20, n);
        check("post_rst_latency", n, 7);
        check("post_rst_sym", int'(sym), 4);
        btn = 8'h00;
        wait_idle("post_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_symbol_encoder.md
Name: button_symbol_encoder

Overview:
- Producer side of the player-input path in the memory game.
- Synchronises and debounces the 8 raw push buttons, then encodes one debounced single press into a 3-bit symbol (0–7).
- Delivers each symbol once to the input-handling logic over a valid/ready handshake.
- Waits for full release before it will accept another press, so one physical press yields exactly one symbol.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a press or a release is accepted; legal range ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, never overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  block enable; when low, the block synchronously returns to IDLE.
- btn  in  8  raw asynchronous buttons, active-high; bit i = symbol i.
- sym_ready  in  1  consumer accepts sym this cycle.
- sym_valid  out  1  sym holds a new symbol.
- sym  out  3  encoded symbol; stable while sym_valid is high.
- multi_err  out  1  one-cycle pulse: a debounced press had more than one button down.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, rst_n low): state=IDLE, sync flops=0, snapshot=0, cnt=0, sym_valid=0, sym=0, multi_err=0, busy=0.
- Synchroniser: btn passes through a 2-flop synchroniser; all FSM logic uses the second flop output (bsync). bsync lags btn by 2 edges.
- IDLE: if en and bsync!=0, latch snapshot=bsync, set cnt=0, go to DEBOUNCE. Otherwise stay in IDLE.
- DEBOUNCE, checked in this priority order:
  1. bsync==0: go to IDLE. Glitch discarded, no output.
  2. bsync!=snapshot: snapshot=bsync, cnt=0, stay.
  3. cnt==DEBOUNCE_CYCLES-1 and snapshot is one-hot: sym=index of the set bit, sym_valid=1, go to EMIT.
  4. cnt==DEBOUNCE_CYCLES-1 and snapshot not one-hot: pulse multi_err for 1 cycle, go to RELEASE. No symbol.
  5. Otherwise: cnt++.
- EMIT:
  - sym_valid=1 and sym held constant.
  - On sym_valid && sym_ready: sym_valid=0 on the next edge, cnt=0, go to RELEASE.
  - Releasing the button during EMIT does not cancel the symbol.
- RELEASE:
  - bsync!=0: cnt=0.
  - bsync==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - bsync==0 otherwise: cnt++.
- Latency: btn first sampled high at edge E and held stable → sym_valid rises at edge E+DEBOUNCE_CYCLES+2.
- Handshake rules:
  - At most one symbol per press–release cycle.
  - sym_ready while sym_valid is low is ignored.
  - sym_valid never drops without acceptance, except on en low or reset.
- en low in any state: next edge state=IDLE, sym_valid=0, cnt=0, multi_err=0. Any pending symbol is dropped; sym keeps its last value.
- Held button at enable: en rising while a button is already held and stable yields one symbol after debounce, not repeated symbols.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).
- cnt saturates logically at DEBOUNCE_CYCLES-1 and never wraps.

Decomposition:
- Shared package memgame_pkg:
  - typedef symbol_t (logic [2:0]).
  - localparam NUM_BTN=8.
  - enum enc_state_t {IDLE, DEBOUNCE, EMIT, RELEASE}.
  - function onehot_to_sym (returns index; caller checks one-hot with $onehot).
- One sub-module, btn_sync: parameterised-width 2-flop synchroniser with asynchronous active-low reset to 0.

Test Plan (DEBOUNCE_CYCLES=4):
- Single press, ready tied high: btn=8'h20 held from edge 0 → sym_valid=1 at edge 6 with sym=5; accepted the same cycle; sym_valid=0 at edge 7. Release held 4+ cycles → busy=0.
- Back-pressure: btn=8'h01, sym_ready=0 for 10 cycles → sym_valid stays 1 and sym=0 throughout, including after btn is released. Raise ready → exactly one transfer.
- Bounce: btn toggles 8'h04/8'h00 every 2 cycles for 12 cycles, then holds 8'h04 → exactly one symbol 2, emitted 6 edges after the final stable high sample.
- Multi-press: btn=8'h09 held → multi_err pulses for 1 cycle at edge 6, sym_valid never rises. Block stays busy until btn=0 for 4 cycles.
- Hold without release: btn=8'h80 held for 50 cycles, ready=1 → exactly one symbol 7, then busy remains 1 (RELEASE). No second symbol until release and re-press.
- Abort paths:
  - en dropped during EMIT → sym_valid=0 at the next edge, state IDLE.
  - rst_n pulsed low mid-DEBOUNCE → all outputs 0 immediately.
  - After either, a fresh press yields a correct symbol.
